// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: state encoding, error causes
// and the big-endian byte/word helpers.
package data_mem_responder_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_BOTH     = 2'd1;
    localparam logic [1:0] ERR_MISALIGN = 2'd2;
    localparam logic [1:0] ERR_RANGE    = 2'd3;

    // Byte lane idx of a big-endian word: lane 0 is bits [31:24].
    function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = w[31:24];
            2'd1:    b = w[23:16];
            2'd2:    b = w[15:8];
            default: b = w[7:0];
        endcase
        return b;
    endfunction

    function automatic logic [31:0] be_word(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input logic [7:0] b3);
        return {b0, b1, b2, b3};
    endfunction

    function automatic logic [1:0] err_cause(input logic rd, input logic wr,
                                             input logic [31:0] addr, input int depth);
        logic [1:0] c;
        if (rd && wr)
            c = ERR_BOTH;
        else if (addr[1:0] != 2'b00)
            c = ERR_MISALIGN;
        else if (addr >= 32'(depth))
            c = ERR_RANGE;
        else
            c = ERR_NONE;
        return c;
    endfunction

endpackage

// File: rtl/data_mem_responder_dmem_array.sv
// Byte-organised storage with a synchronous big-endian word write port and an
// asynchronous word read port. Addresses are assumed word aligned.
module dmem_array
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_BYTES = 128,
    parameter int AW          = $clog2(DEPTH_BYTES)
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [7:0] mem [DEPTH_BYTES];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr]          <= be_byte(wdata, 2'd0);
            mem[waddr + AW'(1)] <= be_byte(wdata, 2'd1);
            mem[waddr + AW'(2)] <= be_byte(wdata, 2'd2);
            mem[waddr + AW'(3)] <= be_byte(wdata, 2'd3);
        end
    end

    assign rdata = be_word(mem[raddr], mem[raddr + AW'(1)],
                           mem[raddr + AW'(2)], mem[raddr + AW'(3)]);

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage data memory responder: wait-state FSM with mRdy/mErr handshake.
// Optional posted writes (1-cycle ack, background drain) under DMEM_POSTED_WR_EN.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_BYTES = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        mRD,
    input  logic        mWR,
    input  logic [31:0] DAddr,
    input  logic [31:0] DataIn,
    output logic [31:0] DataOut,
    output logic        mRdy,
    output logic        mErr
);

    localparam int AW = $clog2(DEPTH_BYTES);

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          op_wr;
    logic [1:0]    cause_q;
    logic [1:0]    cause_in;
    logic [AW-1:0] addr_q;
    logic [31:0]   data_q;
    logic [31:0]   rdata;
    logic          we;

    assign cause_in = err_cause(mRD, mWR, DAddr, DEPTH_BYTES);

`ifdef DMEM_POSTED_WR_EN
    assign we = ((state == ST_RESP) && op_wr && (cause_q == ERR_NONE)) ||
                ((state == ST_DRAIN) && (cnt == 4'd0));
`else
    assign we = (state == ST_RESP) && op_wr && (cause_q == ERR_NONE);
`endif

    dmem_array #(
        .DEPTH_BYTES (DEPTH_BYTES),
        .AW          (AW)
    ) u_array (
        .CLK   (CLK),
        .we    (we),
        .waddr (addr_q),
        .wdata (data_q),
        .raddr (addr_q),
        .rdata (rdata)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_IDLE;
            cnt     <= 4'd0;
            op_wr   <= 1'b0;
            cause_q <= ERR_NONE;
            addr_q  <= '0;
            data_q  <= '0;
            DataOut <= '0;
            mRdy    <= 1'b0;
            mErr    <= 1'b0;
        end else begin
            mRdy <= 1'b0;
            mErr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mRD || mWR) begin
                        addr_q  <= DAddr[AW-1:0];
                        data_q  <= DataIn;
                        op_wr   <= mWR;
                        cause_q <= cause_in;
                        cnt     <= 4'(WAIT_CYCLES);
`ifdef DMEM_POSTED_WR_EN
                        // Clean writes are acknowledged now and committed after the countdown.
                        if (mWR && (cause_in == ERR_NONE)) begin
                            state <= ST_DRAIN;
                            mRdy  <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
`else
                        state <= ST_WAIT;
`endif
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0)
                        state <= ST_RESP;
                    else
                        cnt <= cnt - 4'd1;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    mRdy  <= 1'b1;
                    mErr  <= (cause_q != ERR_NONE);
                    if (!op_wr && (cause_q == ERR_NONE))
                        DataOut <= rdata;
                end
`ifdef DMEM_POSTED_WR_EN
                ST_DRAIN: begin
                    if (cnt == 4'd0)
                        state <= ST_IDLE;
                    else
                        cnt <= cnt - 4'd1;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a byte-array model.
module tb_data_mem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 128;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        mRD = 1'b0;
    logic        mWR = 1'b0;
    logic [31:0] DAddr = '0;
    logic [31:0] DataIn = '0;
    logic [31:0] DataOut;
    logic        mRdy;
    logic        mErr;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  ref_mem [DEPTH];
    logic [31:0] ref_out = '0;

`ifdef DMEM_POSTED_WR_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    data_mem_responder #(
        .DEPTH_BYTES (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .mRD     (mRD),
        .mWR     (mWR),
        .DAddr   (DAddr),
        .DataIn  (DataIn),
        .DataOut (DataOut),
        .mRdy    (mRdy),
        .mErr    (mErr)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input int a);
        return {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]};
    endfunction

    task automatic ref_write(input int a, input logic [31:0] d);
        ref_mem[a]   = d[31:24];
        ref_mem[a+1] = d[23:16];
        ref_mem[a+2] = d[15:8];
        ref_mem[a+3] = d[7:0];
    endtask

    // Drive one request (inputs change #1 after an edge), wait for mRdy and compare.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        int lat;
        int exp_lat;
        bit err_exp;
        err_exp = (rd && wr) || (a[1:0] != 2'b00) || (a >= 32'(DEPTH));
        exp_lat = (POSTED && wr && !err_exp) ? 0 : W + 2;
        mRD = rd; mWR = wr; DAddr = a; DataIn = d;
        @(posedge CLK); #1;
        DAddr = $urandom; DataIn = $urandom;
        lat = 0;
        while (!mRdy && lat < 40) begin
            @(posedge CLK); #1;
            lat++;
        end
        mRD = 1'b0; mWR = 1'b0;
        check("latency", 32'(lat), 32'(exp_lat));
        check("merr", {31'b0, mErr}, {31'b0, err_exp});
        if (!err_exp) begin
            if (wr) ref_write(int'(a), d);
            else    ref_out = ref_word(int'(a));
        end
        check("dataout", DataOut, ref_out);
        @(posedge CLK); #1;
        check("mrdy_pulse", {31'b0, mRdy}, 32'd0);
        check("dataout_hold", DataOut, ref_out);
        if (POSTED && wr && !err_exp)
            repeat (W + 3) @(posedge CLK);
        #1;
    endtask

    task automatic read_expect(input int a, input string tag);
        access(1'b1, 1'b0, 32'(a), 32'd0);
        check(tag, DataOut, ref_word(a));
    endtask

    initial begin
        logic [31:0] a;
        int pick;
        int lat;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_dataout", DataOut, 32'd0);
        check("rst_mrdy", {31'b0, mRdy}, 32'd0);
        check("rst_merr", {31'b0, mErr}, 32'd0);
        RST = 1'b1;
        @(posedge CLK); #1;

        for (int i = 0; i < DEPTH; i += 4)
            access(1'b0, 1'b1, 32'(i), $urandom);

        access(1'b0, 1'b1, 32'h10, 32'h1234_5678);
        read_expect(32'h10, "rd_0x10");
        check("byte_0x10", {24'b0, DataOut[31:24]}, 32'h12);

        access(1'b1, 1'b0, 32'h11, 32'd0);
        read_expect(32'h10, "mem_after_misalign");

        access(1'b0, 1'b1, 32'h80, 32'hCAFE_F00D);
        read_expect(32'h7C, "rd_0x7c_after_range");

        access(1'b1, 1'b1, 32'h30, 32'hA5A5_A5A5);
        read_expect(32'h30, "rd_0x30_after_both");

        // Reset while a write to 0x20 is waiting.
        mWR = 1'b1; DAddr = 32'h20; DataIn = 32'hDEAD_BEEF;
        @(posedge CLK); #1;
        mWR = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        #1;
        check("rstmid_mrdy", {31'b0, mRdy}, 32'd0);
        check("rstmid_merr", {31'b0, mErr}, 32'd0);
        check("rstmid_dataout", DataOut, 32'd0);
        ref_out = '0;
        @(posedge CLK); #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        read_expect(32'h20, "rd_0x20_after_rst");

        for (int n = 0; n < 40; n++) begin
            pick = int'($urandom_range(0, 9));
            if (pick == 0)
                a = {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
            else if (pick == 1)
                a = 32'(DEPTH) + 32'($urandom_range(0, 200));
            else
                a = {25'd0, 5'($urandom_range(0, 31)), 2'b00};
            if (pick == 2)
                access(1'b1, 1'b1, a, $urandom);
            else if ($urandom_range(0, 1) == 1)
                access(1'b0, 1'b1, a, $urandom);
            else
                access(1'b1, 1'b0, a, 32'd0);
        end

`ifdef DMEM_POSTED_WR_EN
        mWR = 1'b1; DAddr = 32'h24; DataIn = 32'h0BAD_F00D;
        @(posedge CLK); #1;
        check("posted_ack", {31'b0, mRdy}, 32'd1);
        check("posted_ack_err", {31'b0, mErr}, 32'd0);
        ref_write(32'h24, 32'h0BAD_F00D);
        mWR = 1'b0; mRD = 1'b1; DAddr = 32'h24;
        lat = 0;
        do begin
            @(posedge CLK); #1;
            lat++;
        end while (!mRdy && lat < 60);
        mRD = 1'b0;
        check("posted_read_delayed", {31'b0, lat > W + 3}, 32'd1);
        ref_out = ref_word(32'h24);
        check("posted_read_data", DataOut, ref_out);
        @(posedge CLK); #1;
`else
        lat = 0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Word-wide data memory that answers the CPU control FSM's MEM-state strobes: mRD for lw, mWR for sw.
- Adds configurable wait states and a mRdy/mErr completion handshake, so the control FSM holds in MEM until the access completes.
- Sits between the datapath (ALU result as DAddr, rt register value as DataIn) and the write-back mux (DataOut feeds the DBDataSrc=1 path).

Parameters:
- DEPTH_BYTES, 128, memory size in bytes; must be a power of two and a multiple of 4.
- WAIT_CYCLES, 2, extra wait states before completion; legal range 0..15.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- mRD  in  1  read request; held high by the requester until mRdy.
- mWR  in  1  write request; held high by the requester until mRdy.
- DAddr  in  32  byte address.
- DataIn  in  32  write data.
- DataOut  out  32  read data; valid when mRdy=1 and mErr=0, then held.
- mRdy  out  1  one-cycle completion pulse.
- mErr  out  1  qualifies mRdy; 1 means the access was rejected.

Behaviour:
- Reset (RST=0, asynchronous): FSM to IDLE, wait counter 0, DataOut=0, mRdy=0, mErr=0. Memory array contents are not reset.
- Storage is big-endian: byte DAddr holds bits [31:24], byte DAddr+3 holds bits [7:0].
- FSM states:
  - IDLE: if mRD or mWR is high, latch DAddr, DataIn and the operation, load the counter with WAIT_CYCLES, go to WAIT.
  - WAIT: decrement the counter each cycle; when it is 0, go to RESP.
  - RESP: perform the access and assert mRdy for exactly this cycle, then go to IDLE.
- Latency: mRdy asserts WAIT_CYCLES+2 cycles after the edge where the request is first sampled high.
  - With WAIT_CYCLES=0: request sampled at edge n, WAIT at n+1, mRdy high during the cycle after edge n+2.
- Latched inputs: DAddr and DataIn are captured only in IDLE. Changes during WAIT/RESP are ignored.
- Writes commit on the RESP clock edge. Reset before that edge means no commit.
- Error conditions (checked on the latched values; mRdy=1 and mErr=1 in RESP, no memory change, DataOut unchanged):
  - mRD and mWR both high at acceptance.
  - DAddr[1:0] not equal to 0 (misaligned).
  - DAddr >= DEPTH_BYTES (out of range).
- Back-to-back requests: a request still high in the cycle after RESP is treated as a new request. The requester must drop the strobe on seeing mRdy; the control FSM leaves MEM on mRdy.
- DataOut: updated only on a successful read, and held across writes and idle cycles.

Optional Feature:
- Macro: DMEM_POSTED_WR_EN.
- Defined:
  - A non-error write pulses mRdy in the cycle right after acceptance (1-cycle ack).
  - The FSM then enters DRAIN, runs the WAIT_CYCLES countdown, and commits when the countdown finishes.
  - While in DRAIN, new requests are not accepted; they wait until the FSM returns to IDLE.
  - Write errors are still reported through the normal WAIT/RESP timing.
  - Reset during DRAIN drops the posted write.
- Undefined: writes use the same timing as reads; the DRAIN state does not exist.

Decomposition:
- Shared package (e.g. mem_pkg): FSM state encoding (IDLE, WAIT, RESP, DRAIN), the big-endian pack/unpack function, and the error-cause constants.
- Sub-module: dmem_array, a byte array with a synchronous 32-bit word write port and an asynchronous word read port. The responder owns the FSM, counter and handshake.

Test Plan:
- Reset, then write 0x12345678 to address 0x10 and read it back (WAIT_CYCLES=2) -> read gives mRdy at cycle 4 with DataOut=0x12345678; byte 0x10 holds 0x12.
- Read from 0x11 -> mRdy=1, mErr=1; DataOut keeps its previous value; memory unchanged.
- Write to 0x80 with DEPTH_BYTES=128 -> mErr=1; reading 0x7C returns its prior value.
- mRD and mWR both high -> mErr=1 and no write occurs.
- RST pulled low during WAIT of a write of 0xDEADBEEF to 0x20 -> outputs go to 0 immediately; a later read of 0x20 returns the old value.
- With DMEM_POSTED_WR_EN: write to 0x24, then a read of 0x24 right away -> write mRdy the cycle after acceptance; the read is accepted only after drain and returns the new data.
